sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_sdram_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Multi-port SDRAM request arbiter. Port 0 has fixed top priority and the other ports
// share the controller round-robin. A small tag FIFO steers in-order read data back to its requester.
module sdram_arbiter #(
  parameter int NREQ   = 3,
  parameter int ADDRW  = 23,
  parameter int DATAW  = 32,
  parameter int MAXOUT = 4
) (
  input  logic                  clk_draw,
  input  logic                  rst_draw,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ-1:0]       we_i,
  input  logic [NREQ*ADDRW-1:0] addr_i,
  input  logic [NREQ*DATAW-1:0] data_i,
  output logic [NREQ-1:0]       ack_o,
  output logic [NREQ-1:0]       rd_valid_o,
  output logic [DATAW-1:0]      rd_data_o,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [ADDRW-1:0]      ram_addr,
  output logic [DATAW-1:0]      ram_data,
  input  logic                  ram_ack,
  input  logic                  ram_valid,
  input  logic [DATAW-1:0]      ram_q,
  output logic                  overflow_o
);
  localparam int IW = $clog2(NREQ);
  localparam int PW = (MAXOUT > 1) ? $clog2(MAXOUT) : 1;
  localparam int CW = $clog2(MAXOUT) + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_reg;
  logic [IW-1:0]    grant_reg;
  logic [IW-1:0]    rr_reg;
  logic             ram_req_reg;
  logic             ram_we_reg;
  logic [ADDRW-1:0] ram_addr_reg;
  logic [DATAW-1:0] ram_data_reg;

  logic [IW-1:0]    tag_mem [MAXOUT];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    cnt_reg;
  logic [NREQ-1:0]  rd_valid_reg;
  logic [DATAW-1:0] rd_data_reg;
  logic             overflow_reg;

  logic [ADDRW-1:0] port_addr [NREQ];
  logic [DATAW-1:0] port_data [NREQ];
  logic [NREQ-1:0]  elig;
  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic             push;
  logic             pop;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_port
      assign port_addr[gi] = addr_i[gi*ADDRW +: ADDRW];
      assign port_data[gi] = data_i[gi*DATAW +: DATAW];
      // Writes never occupy a tag, so only reads are throttled by the FIFO depth.
      assign elig[gi] = req_i[gi] & (we_i[gi] | (cnt_reg < CW'(MAXOUT)));
    end
  endgenerate

  function automatic logic [IW-1:0] rr_port(input logic [IW-1:0] base, input int k);
    int p;
    p = 1 + ((int'(base) - 1 + k) % (NREQ - 1));
    return IW'(p);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(MAXOUT - 1)) ? '0 : ptr + PW'(1);
  endfunction

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    if (elig[0]) begin
      pick_valid = 1'b1;
    end else begin
      for (int k = 0; k < NREQ - 1; k++) begin
        if (!pick_valid && elig[rr_port(rr_reg, k)]) begin
          pick_valid = 1'b1;
          pick_idx   = rr_port(rr_reg, k);
        end
      end
    end
  end

  always_ff @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      rr_reg       <= IW'(1);
      ram_req_reg  <= 1'b0;
      ram_we_reg   <= 1'b0;
      ram_addr_reg <= '0;
      ram_data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            grant_reg    <= pick_idx;
            ram_req_reg  <= 1'b1;
            ram_we_reg   <= we_i[pick_idx];
            ram_addr_reg <= port_addr[pick_idx];
            ram_data_reg <= port_data[pick_idx];
            state_reg    <= BUSY;
            // Port 0 wins outside the rotation and leaves the pointer untouched.
            if (pick_idx != '0)
              rr_reg <= (pick_idx == IW'(NREQ - 1)) ? IW'(1) : pick_idx + IW'(1);
          end
        end
        BUSY: begin
          if (ram_ack) begin
            ram_req_reg <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign push = (state_reg == BUSY) && ram_ack && !ram_we_reg;
  assign pop  = ram_valid && (cnt_reg != '0);

  always_ff @(posedge clk_draw) begin
    if (push)
      tag_mem[wr_ptr_reg] <= grant_reg;
  end

  always_ff @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      cnt_reg      <= '0;
      rd_valid_reg <= '0;
      rd_data_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + CW'(1);
        2'b01:   cnt_reg <= cnt_reg - CW'(1);
        default: cnt_reg <= cnt_reg;
      endcase
      rd_valid_reg <= pop ? (NREQ'(1) << tag_mem[rd_ptr_reg]) : '0;
      if (pop)
        rd_data_reg <= ram_q;
      if (ram_valid && (cnt_reg == '0))
        overflow_reg <= 1'b1;
    end
  end

  assign ack_o      = ((state_reg == BUSY) && ram_ack) ? (NREQ'(1) << grant_reg) : '0;
  assign ram_req    = ram_req_reg;
  assign ram_we     = ram_we_reg;
  assign ram_addr   = ram_addr_reg;
  assign ram_data   = ram_data_reg;
  assign rd_valid_o = rd_valid_reg;
  assign rd_data_o  = rd_data_reg;
  assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized bench for sdram_arbiter: a transaction-level model predicts grants, acks,
// read-data steering and the overflow flag, with directed reset and overflow scenarios at the end.
module tb_sdram_arbiter;
  localparam int NREQ   = 3;
  localparam int ADDRW  = 23;
  localparam int DATAW  = 32;
  localparam int MAXOUT = 4;

  logic                  clk_draw = 1'b0;
  logic                  rst_draw = 1'b1;
  logic [NREQ-1:0]       req_i    = '0;
  logic [NREQ-1:0]       we_i     = '0;
  logic [NREQ*ADDRW-1:0] addr_i   = '0;
  logic [NREQ*DATAW-1:0] data_i   = '0;
  logic [NREQ-1:0]       ack_o;
  logic [NREQ-1:0]       rd_valid_o;
  logic [DATAW-1:0]      rd_data_o;
  logic                  ram_req;
  logic                  ram_we;
  logic [ADDRW-1:0]      ram_addr;
  logic [DATAW-1:0]      ram_data;
  logic                  ram_ack   = 1'b0;
  logic                  ram_valid = 1'b0;
  logic [DATAW-1:0]      ram_q     = '0;
  logic                  overflow_o;

  int total = 0;
  int bad   = 0;

  // Reference model: one transaction in flight, a queue of read owners, and a rotating start port.
  bit               m_issued;
  int               m_grant;
  bit               m_we;
  logic [ADDRW-1:0] m_addr;
  logic [DATAW-1:0] m_data;
  int               m_rr;
  int               m_tags[$];
  bit               m_ovf;
  logic [NREQ-1:0]  m_rdv;
  logic [DATAW-1:0] m_rdd;

  sdram_arbiter #(.NREQ(NREQ), .ADDRW(ADDRW), .DATAW(DATAW), .MAXOUT(MAXOUT)) dut (
    .clk_draw(clk_draw), .rst_draw(rst_draw),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
    .ack_o(ack_o), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_ack(ram_ack), .ram_valid(ram_valid), .ram_q(ram_q),
    .overflow_o(overflow_o)
  );

  always #5 clk_draw = ~clk_draw;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_issued = 1'b0;
    m_grant  = 0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_data   = '0;
    m_rr     = 1;
    m_tags.delete();
    m_ovf    = 1'b0;
    m_rdv    = '0;
    m_rdd    = '0;
  endtask

  // Advance the model across one rising edge using the inputs currently presented.
  task automatic model_step();
    int cnt = m_tags.size();
    int win = -1;
    logic [NREQ-1:0] nrdv = '0;
    if (ram_valid) begin
      if (m_tags.size() > 0) begin
        int h = m_tags.pop_front();
        nrdv[h] = 1'b1;
        m_rdd   = ram_q;
        $display("read return port=%0d q=%h", h, ram_q);
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (m_issued) begin
      if (ram_ack) begin
        m_issued = 1'b0;
        if (!m_we) m_tags.push_back(m_grant);
      end
    end else begin
      if (req_i[0] && (we_i[0] || cnt < MAXOUT)) win = 0;
      for (int k = 0; k < NREQ - 1; k++) begin
        int p = 1 + ((m_rr - 1 + k) % (NREQ - 1));
        if (win < 0 && req_i[p] && (we_i[p] || cnt < MAXOUT)) win = p;
      end
      if (win >= 0) begin
        m_issued = 1'b1;
        m_grant  = win;
        m_we     = we_i[win];
        m_addr   = addr_i[win*ADDRW +: ADDRW];
        m_data   = data_i[win*DATAW +: DATAW];
        if (win > 0) m_rr = (win == NREQ - 1) ? 1 : win + 1;
      end
    end
    m_rdv = nrdv;
  endtask

  // One clock: check outputs before the edge, advance the model, then retire the acked requester.
  task automatic tick();
    logic [NREQ-1:0] exp_ack = '0;
    int acked = -1;
    @(negedge clk_draw);
    if (m_issued && ram_ack) begin
      exp_ack[m_grant] = 1'b1;
      acked = m_grant;
    end
    check_val("ram_req", ram_req, m_issued);
    if (m_issued) begin
      check_val("ram_we", ram_we, m_we);
      check_val("ram_addr", ram_addr, m_addr);
      check_val("ram_data", ram_data, m_data);
    end
    check_val("ack_o", ack_o, exp_ack);
    check_val("rd_valid_o", rd_valid_o, m_rdv);
    if (m_rdv != '0) check_val("rd_data_o", rd_data_o, m_rdd);
    check_val("overflow_o", overflow_o, m_ovf);
    if (acked >= 0)
      $display("ack port=%0d we=%0b addr=%h data=%h", acked, m_we, m_addr, m_data);
    model_step();
    @(posedge clk_draw);
    #1;
    if (acked >= 0) req_i[acked] = 1'b0;
  endtask

  task automatic drive_random(input int val_pct);
    for (int i = 0; i < NREQ; i++) begin
      if (!req_i[i] && $urandom_range(0, 99) < 45) begin
        req_i[i] = 1'b1;
        we_i[i]  = ($urandom_range(0, 99) < 40);
        addr_i[i*ADDRW +: ADDRW] = ADDRW'($urandom);
        data_i[i*DATAW +: DATAW] = $urandom;
      end
    end
    ram_ack   = ($urandom_range(0, 99) < 55);
    ram_valid = (m_tags.size() > 0) && ($urandom_range(0, 99) < val_pct);
    ram_q     = $urandom;
  endtask

  initial begin
    model_reset();
    rst_draw = 1'b1;
    ram_ack  = 1'b1;
    repeat (2) @(posedge clk_draw);
    @(negedge clk_draw);
    check_val("rst ram_req", ram_req, 1'b0);
    check_val("rst ram_we", ram_we, 1'b0);
    check_val("rst ack_o", ack_o, '0);
    check_val("rst rd_valid_o", rd_valid_o, '0);
    check_val("rst rd_data_o", rd_data_o, '0);
    check_val("rst overflow_o", overflow_o, 1'b0);
    ram_ack = 1'b0;
    @(posedge clk_draw);
    #1;
    rst_draw = 1'b0;

    // Random traffic; the middle phase starves ram_valid so reads back up against MAXOUT.
    for (int c = 0; c < 2400; c++) begin
      drive_random((c >= 800 && c < 1600) ? 4 : 40);
      tick();
    end

    // Park every requester, then load the FIFO with port 1 reads acked immediately.
    req_i = '0;
    ram_valid = 1'b0;
    ram_ack = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (!req_i[1] && !m_issued) begin
        req_i[1] = 1'b1;
        we_i[1]  = 1'b0;
        addr_i[1*ADDRW +: ADDRW] = ADDRW'($urandom);
      end
      tick();
    end
    req_i = '0;
    for (int c = 0; c < 4; c++) tick();
    check_val("fifo full", m_tags.size(), MAXOUT);

    // A write from port 2 is held in flight by withholding ram_ack, then reset strikes.
    ram_ack = 1'b0;
    req_i[2] = 1'b1;
    we_i[2]  = 1'b1;
    addr_i[2*ADDRW +: ADDRW] = ADDRW'($urandom);
    data_i[2*DATAW +: DATAW] = $urandom;
    for (int c = 0; c < 4; c++) tick();
    check_val("write while full", ram_req, 1'b1);
    @(negedge clk_draw);
    ram_ack  = 1'b1;
    rst_draw = 1'b1;
    #1;
    check_val("async rst ram_req", ram_req, 1'b0);
    check_val("async rst ack_o", ack_o, '0);
    model_reset();
    req_i   = '0;
    ram_ack = 1'b0;
    @(posedge clk_draw);
    #1;
    rst_draw = 1'b0;

    // Any surviving tag would absorb this ram_valid; with the FIFO cleared it must overflow.
    ram_valid = 1'b1;
    ram_q     = 32'hDEAD_BEEF;
    tick();
    ram_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    check_val("overflow sticky", overflow_o, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
